// File: rtl/gp_trig_cfg_bank_if.sv
// Slave-side request/response bundle between the address decoder and the
// trigger-configuration bank.
interface gp_trig_cfg_bank_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8
);
  logic                        reg_en;
  logic [TRANS_ADDR_WIDTH-1:0] trans_addr;
  logic                        slv_o_valid;
  logic                        slv_o_rd0_wr1;
  logic [DATA_WIDTH-1:0]       slv_o_wr_data;
  logic                        slv_i_ready;
  logic [DATA_WIDTH-1:0]       slv_i_rd_data;
  logic                        slv_i_rd_valid;
  logic                        slv_i_err;

  modport master (
    output reg_en, trans_addr, slv_o_valid, slv_o_rd0_wr1, slv_o_wr_data,
    input  slv_i_ready, slv_i_rd_data, slv_i_rd_valid, slv_i_err
  );

  modport slave (
    input  reg_en, trans_addr, slv_o_valid, slv_o_rd0_wr1, slv_o_wr_data,
    output slv_i_ready, slv_i_rd_data, slv_i_rd_valid, slv_i_err
  );
endinterface

// File: rtl/gp_trig_cfg_bank.sv
// Trigger-configuration register bank: CFG words, lock, status and ID over the
// slave bus, plus an atomic snapshot of all CFG words for the engine FSM.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for a slave request or a snapshot request
// ST_RD_RESP | read response (and error flag) presented for one cycle
// ST_SNAP    | snapshot valid/empty pulse presented for one cycle
module gp_trig_cfg_bank #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          TRANS_ADDR_WIDTH = 8,
  parameter int          NUM_TRIG         = 4,
  parameter logic [31:0] ID_VALUE         = 32'h4750_0002
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  gp_trig_cfg_bank_if.slave              slv,
  input  logic                           reg_rd_en,
  output logic [NUM_TRIG*DATA_WIDTH-1:0] rd_trig_config,
  output logic                           reg_rd_valid,
  output logic                           reg_rd_empty,
  output logic                           cfg_locked
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_RESP, ST_SNAP} state_t;

  localparam logic [TRANS_ADDR_WIDTH-1:0] ADDR_CTRL   = TRANS_ADDR_WIDTH'(8'hFD);
  localparam logic [TRANS_ADDR_WIDTH-1:0] ADDR_STATUS = TRANS_ADDR_WIDTH'(8'hFE);
  localparam logic [TRANS_ADDR_WIDTH-1:0] ADDR_ID     = TRANS_ADDR_WIDTH'(8'hFF);
  localparam int LOCK_BIT = (DATA_WIDTH > 16) ? 16 : 0;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          cfg_q [NUM_TRIG];
  logic [DATA_WIDTH-1:0]          cfg_d [NUM_TRIG];
  logic                           lock_q, lock_d;
  logic [DATA_WIDTH-1:0]          rd_data_q, rd_data_d;
  logic                           rd_valid_q, rd_valid_d;
  logic                           err_q, err_d;
  logic [NUM_TRIG*DATA_WIDTH-1:0] snap_q, snap_d;
  logic                           snap_valid_q, snap_valid_d;
  logic                           snap_empty_q, snap_empty_d;

  logic [NUM_TRIG-1:0]            cfg_hit;
  logic [DATA_WIDTH-1:0]          cfg_rd;
  logic [DATA_WIDTH-1:0]          status_word;
  logic [NUM_TRIG*DATA_WIDTH-1:0] cfg_packed;
  logic                           is_ctrl, is_status, is_id, any_cfg, accept;

  always_comb begin
    cfg_hit     = '0;
    cfg_rd      = '0;
    status_word = '0;
    cfg_packed  = '0;
    for (int k = 0; k < NUM_TRIG; k++) begin
      cfg_hit[k]     = (slv.trans_addr == TRANS_ADDR_WIDTH'(k));
      status_word[k] = |cfg_q[k];
      cfg_packed[k*DATA_WIDTH +: DATA_WIDTH] = cfg_q[k];
      if (cfg_hit[k]) cfg_rd = cfg_q[k];
    end
    if (DATA_WIDTH > 16) status_word[LOCK_BIT] = lock_q;
    any_cfg   = |status_word[NUM_TRIG-1:0];
    is_ctrl   = (slv.trans_addr == ADDR_CTRL);
    is_status = (slv.trans_addr == ADDR_STATUS);
    is_id     = (slv.trans_addr == ADDR_ID);
    accept    = slv.reg_en && slv.slv_o_valid && (state_q == ST_IDLE);

    state_d      = state_q;
    cfg_d        = cfg_q;
    lock_d       = lock_q;
    rd_data_d    = '0;
    rd_valid_d   = 1'b0;
    err_d        = 1'b0;
    snap_d       = snap_q;
    snap_valid_d = 1'b0;
    snap_empty_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && !slv.slv_o_rd0_wr1) begin
          state_d    = ST_RD_RESP;
          rd_valid_d = 1'b1;
          if (|cfg_hit)       rd_data_d = cfg_rd;
          else if (is_ctrl)   rd_data_d = DATA_WIDTH'(lock_q);
          else if (is_status) rd_data_d = status_word;
          else if (is_id)     rd_data_d = DATA_WIDTH'(ID_VALUE);
          else                err_d     = 1'b1;
        end else if (accept) begin
          if (|cfg_hit) begin
            if (lock_q) err_d = 1'b1;
            else begin
              for (int k = 0; k < NUM_TRIG; k++)
                if (cfg_hit[k]) cfg_d[k] = slv.slv_o_wr_data;
            end
          end else if (is_ctrl) begin
            lock_d = lock_q | slv.slv_o_wr_data[0];
          end else begin
            err_d = 1'b1;
          end
        end else if (reg_rd_en) begin
          // All words captured on one edge so the engine never sees a torn set.
          state_d      = ST_SNAP;
          snap_d       = cfg_packed;
          snap_valid_d = any_cfg;
          snap_empty_d = !any_cfg;
        end
      end
      ST_RD_RESP: state_d = ST_IDLE;
      ST_SNAP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      for (int k = 0; k < NUM_TRIG; k++) cfg_q[k] <= '0;
      lock_q       <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      snap_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      lock_q       <= lock_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      err_q        <= err_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      snap_empty_q <= snap_empty_d;
    end
  end

  assign slv.slv_i_ready    = (state_q == ST_IDLE);
  assign slv.slv_i_rd_data  = rd_data_q;
  assign slv.slv_i_rd_valid = rd_valid_q;
  assign slv.slv_i_err      = err_q;
  assign rd_trig_config     = snap_q;
  assign reg_rd_valid       = snap_valid_q;
  assign reg_rd_empty       = snap_empty_q;
  assign cfg_locked         = lock_q;

endmodule
